// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers for the pipelined signed adder tree.
// Every level halves the element count, rounding up, and grows the element
// width by one bit. After tree_levels() levels a single element of out_width()
// bits remains.
package adder_tree_pkg;

    // Number of pairwise-add levels needed to reduce n operands to one.
    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

    // Width of the exact signed sum of n operands of w bits each.
    function automatic int out_width(input int w, input int n);
        return w + $clog2(n);
    endfunction

    // Element count at level l, i.e. ceil(n / 2^l). Level 0 is the raw operand set.
    function automatic int level_count(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered reduction level of the adder tree.
// Takes N_IN packed signed W-bit elements and produces ceil(N_IN/2) packed
// signed (W+1)-bit elements. Element i of the output is the sum of input
// elements 2i and 2i+1. When N_IN is odd, the last input element has no
// partner. It is sign-extended and forwarded, so it sees the same one-cycle
// delay as the sums.
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N_IN*W-1:0]                     din,
    output logic [level_count(N_IN, 1)*(W+1)-1:0] dout
);

    localparam int N_OUT = level_count(N_IN, 1);
    localparam int W_OUT = W + 1;

    logic [N_OUT*W_OUT-1:0] sum_d;

    // Pair up adjacent elements. Each pair is sign-extended by one bit before
    // the add, so the result never overflows.
    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
        if (2 * i + 1 < N_IN) begin : g_add
            assign sum_d[i*W_OUT +: W_OUT] =
                {din[(2*i+1)*W-1], din[2*i*W +: W]} +
                {din[(2*i+2)*W-1], din[(2*i+1)*W +: W]};
        end else begin : g_pass
            assign sum_d[i*W_OUT +: W_OUT] = {din[(2*i+1)*W-1], din[2*i*W +: W]};
        end
    end

    // Register the level's results; an asynchronous reset discards in-flight sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= sum_d;
        end
    end

endmodule

// File: rtl/adder_tree.sv
// Pipelined signed adder tree.
// Sums INPUT_NUM packed signed IN_WIDTH-bit operands into one exact signed result.
// Pipeline layout:
//   - input register
//   - LEVELS registered pairwise-add levels
//   - output register
// This gives a latency of LEVELS+2 clock edges and accepts one vector per cycle.
//
// Optional feature: macro ADDER_TREE_VALID_EN adds the in_valid/out_valid ports.
//
// Valid semantics (ADDER_TREE_VALID_EN):
//   - There is no ready and no backpressure.
//   - din is consumed on every rising edge.
//   - in_valid only marks whether that vector is meaningful.
//   - out_valid is high exactly when dout holds the sum of a vector that was
//     sampled with in_valid=1.
//   - dout updates every cycle regardless of out_valid.
module adder_tree
    import adder_tree_pkg::*;
#(
    parameter int INPUT_NUM = 18,
    parameter int IN_WIDTH  = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
`ifdef ADDER_TREE_VALID_EN
    input  logic                                        in_valid,
    output logic                                        out_valid,
`endif
    input  logic [INPUT_NUM*IN_WIDTH-1:0]               din,
    output logic [out_width(IN_WIDTH, INPUT_NUM)-1:0]   dout
);

    localparam int LEVELS    = tree_levels(INPUT_NUM);
    localparam int OUT_WIDTH = out_width(IN_WIDTH, INPUT_NUM);

    logic [INPUT_NUM*IN_WIDTH-1:0] din_q;
    logic [OUT_WIDTH-1:0]          tree_sum;

    // Stage 0: capture the raw operand vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else begin
            din_q <= din;
        end
    end

    // Reduction levels.
    // Level l consumes level_count(INPUT_NUM, l) elements of IN_WIDTH+l bits.
    // It produces half as many elements (rounded up), each one bit wider.
    // The last level therefore yields a single OUT_WIDTH-bit element.
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N_IN  = level_count(INPUT_NUM, l);
        localparam int N_OUT = level_count(INPUT_NUM, l + 1);
        localparam int W_IN  = IN_WIDTH + l;

        logic [N_IN*W_IN-1:0]      lvl_in;
        logic [N_OUT*(W_IN+1)-1:0] lvl_out;

        if (l == 0) begin : g_src_din
            assign lvl_in = din_q;
        end else begin : g_src_prev
            assign lvl_in = g_lvl[l-1].lvl_out;
        end

        adder_tree_stage #(
            .N_IN (N_IN),
            .W    (W_IN)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (lvl_in),
            .dout  (lvl_out)
        );
    end

    assign tree_sum = g_lvl[LEVELS-1].lvl_out;

    // Output register: dout is stable for a whole cycle after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= tree_sum;
        end
    end

`ifdef ADDER_TREE_VALID_EN
    // in_valid rides a LEVELS+2 deep shift register so it lines up with dout.
    logic [LEVELS+1:0] valid_sr;

    // Shift the valid flag along with the data pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[LEVELS:0], in_valid};
        end
    end

    assign out_valid = valid_sr[LEVELS+1];
`else
    // Without the valid ports the datapath is unchanged; nothing tracks validity.
`endif

endmodule

// File: tb/tb_adder_tree.sv
// Self-checking bench for adder_tree.
// Compares every dout against an operand-by-operand arithmetic sum.
// Covers the default 18x8 configuration plus 2x8, 9x16 and 16x8 instances.
// Valid-port checks are compiled in when ADDER_TREE_VALID_EN is defined.
module tb_adder_tree;

    localparam int NUM = 18;
    localparam int IW  = 8;
    localparam int OW  = 13;
    localparam int LAT = 7;

    localparam int N2_OW  = 9;
    localparam int N2_LAT = 3;
    localparam int N9_OW  = 20;
    localparam int N9_LAT = 6;
    localparam int N16_OW = 12;
    localparam int N16_LAT = 6;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [NUM*IW-1:0]  din;
    logic [OW-1:0]      dout;
    logic [2*8-1:0]     din_n2;
    logic [N2_OW-1:0]   dout_n2;
    logic [9*16-1:0]    din_n9;
    logic [N9_OW-1:0]   dout_n9;
    logic [16*8-1:0]    din_n16;
    logic [N16_OW-1:0]  dout_n16;
`ifdef ADDER_TREE_VALID_EN
    logic               out_valid;
    logic               out_valid_n2;
    logic               out_valid_n9;
    logic               out_valid_n16;
`endif

    int checks   = 0;
    int failures = 0;

    logic [OW-1:0] exp_q[$];
    logic          expv_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    adder_tree #(.INPUT_NUM(NUM), .IN_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_VALID_EN
        .in_valid(in_valid), .out_valid(out_valid),
`endif
        .din(din), .dout(dout));

    adder_tree #(.INPUT_NUM(2), .IN_WIDTH(8)) dut_n2 (
        .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_VALID_EN
        .in_valid(in_valid), .out_valid(out_valid_n2),
`endif
        .din(din_n2), .dout(dout_n2));

    adder_tree #(.INPUT_NUM(9), .IN_WIDTH(16)) dut_n9 (
        .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_VALID_EN
        .in_valid(in_valid), .out_valid(out_valid_n9),
`endif
        .din(din_n9), .dout(dout_n9));

    adder_tree #(.INPUT_NUM(16), .IN_WIDTH(8)) dut_n16 (
        .clk(clk), .rst_n(rst_n),
`ifdef ADDER_TREE_VALID_EN
        .in_valid(in_valid), .out_valid(out_valid_n16),
`endif
        .din(din_n16), .dout(dout_n16));

    // ---------------- reference model ----------------
    // Plain two's-complement sum of n operands of w bits packed LSB-first.
    function automatic longint sum_ops(input logic [287:0] v, input int n, input int w);
        longint s;
        longint op;
        s = 0;
        for (int j = 0; j < n; j++) begin
            op = 0;
            for (int b = 0; b < w; b++) op[b] = v[j*w + b];
            if (v[j*w + w - 1]) op = op - (longint'(1) << w);
            s = s + op;
        end
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_fill(input logic [IW-1:0] a, input logic [IW-1:0] b);
        for (int j = 0; j < NUM; j++) din[j*IW +: IW] = (j % 2 == 0) ? a : b;
    endtask

    task automatic drive_random();
        for (int j = 0; j < NUM; j++) din[j*IW +: IW] = IW'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        drive_fill(8'h7F, 8'h7F);
        din_n2  = {2{8'h7F}};
        din_n9  = {9{16'h007F}};
        din_n16 = {16{8'h7F}};
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL reset_dout actual=%0d required=0", $signed(dout));
        end
`ifdef ADDER_TREE_VALID_EN
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid actual=%b required=0", out_valid);
        end
`endif
        rst_n = 1'b1;
        // Edges 1..6 after release: still zero.
        for (int e = 1; e <= LAT - 1; e++) begin
            @(negedge clk);
            checks++;
            if (dout !== '0) begin
                failures++;
                $display("FAIL reset_latency_edge%0d actual=%0d required=0", e, $signed(dout));
            end
        end
        @(negedge clk);
        checks++;
        if (dout !== OW'(2286)) begin
            failures++;
            $display("FAIL reset_first_sum actual=%0d required=2286", $signed(dout));
        end
        checks++;
        if (dout_n2 !== N2_OW'(254)) begin
            failures++;
            $display("FAIL n2_const actual=%0d required=254", $signed(dout_n2));
        end
        checks++;
        if (dout_n9 !== N9_OW'(1143)) begin
            failures++;
            $display("FAIL n9_const actual=%0d required=1143", $signed(dout_n9));
        end
        checks++;
        if (dout_n16 !== N16_OW'(2032)) begin
            failures++;
            $display("FAIL n16_const actual=%0d required=2032", $signed(dout_n16));
        end
    endtask

    task automatic test_extremes();
        drive_fill(8'h80, 8'h80);
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (dout !== OW'(2286)) begin
            failures++;
            $display("FAIL extreme_hold_prev actual=%0d required=2286", $signed(dout));
        end
        @(negedge clk);
        checks++;
        if (dout !== 13'h1700) begin
            failures++;
            $display("FAIL extreme_min actual=%0d required=-2304", $signed(dout));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== 13'h1700) begin
            failures++;
            $display("FAIL extreme_min_hold actual=%0d required=-2304", $signed(dout));
        end
        drive_fill(8'h80, 8'h7F);
        repeat (LAT) @(negedge clk);
        checks++;
        if ($signed(dout) !== -13'sd9) begin
            failures++;
            $display("FAIL extreme_alternating actual=%0d required=-9", $signed(dout));
        end
    endtask

    task automatic test_random_hold();
        logic [OW-1:0] e;
        for (int v = 0; v < 6; v++) begin
            drive_random();
            e = OW'(sum_ops(288'(din), NUM, IW));
            repeat (LAT) @(negedge clk);
            checks++;
            if (dout !== e) begin
                failures++;
                $display("FAIL random_hold_%0d actual=%0d required=%0d", v, $signed(dout), $signed(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] e;
        logic          ev;
        exp_q.delete();
        expv_q.delete();
        for (int t = 0; t < 100 + LAT; t++) begin
            @(negedge clk);
            if (exp_q.size() == LAT) begin
                e  = exp_q.pop_front();
                ev = expv_q.pop_front();
                checks++;
                if (dout !== e) begin
                    failures++;
                    $display("FAIL stream_t%0d actual=%0d required=%0d", t, $signed(dout), $signed(e));
                end
`ifdef ADDER_TREE_VALID_EN
                checks++;
                if (out_valid !== ev) begin
                    failures++;
                    $display("FAIL stream_valid_t%0d actual=%b required=%b", t, out_valid, ev);
                end
`endif
            end
            drive_random();
            in_valid = 1'($urandom_range(0, 1));
            exp_q.push_back(OW'(sum_ops(288'(din), NUM, IW)));
            expv_q.push_back(in_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [OW-1:0] e;
        logic          ev;
        exp_q.delete();
        expv_q.delete();
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            drive_random();
            in_valid = 1'b1;
        end
        // Half-cycle reset pulse, entirely between two rising edges.
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL midreset_async_clear actual=%0d required=0", $signed(dout));
        end
`ifdef ADDER_TREE_VALID_EN
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid_clear actual=%b required=0", out_valid);
        end
`endif
        #2 rst_n = 1'b1;
        // The vector still on din is the first one sampled after release.
        exp_q.push_back(OW'(sum_ops(288'(din), NUM, IW)));
        expv_q.push_back(in_valid);
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            if (exp_q.size() == LAT) begin
                e  = exp_q.pop_front();
                ev = expv_q.pop_front();
            end else begin
                e  = '0;
                ev = 1'b0;
            end
            checks++;
            if (dout !== e) begin
                failures++;
                $display("FAIL midreset_t%0d actual=%0d required=%0d", t, $signed(dout), $signed(e));
            end
`ifdef ADDER_TREE_VALID_EN
            checks++;
            if (out_valid !== ev) begin
                failures++;
                $display("FAIL midreset_valid_t%0d actual=%b required=%b", t, out_valid, ev);
            end
`endif
            drive_random();
            in_valid = 1'($urandom_range(0, 1));
            exp_q.push_back(OW'(sum_ops(288'(din), NUM, IW)));
            expv_q.push_back(in_valid);
        end
    endtask

    task automatic test_param_sweep();
        longint h2[0:63];
        longint h9[0:63];
        longint h16[0:63];
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t >= N2_LAT) begin
                checks++;
                if (dout_n2 !== N2_OW'(h2[t-N2_LAT])) begin
                    failures++;
                    $display("FAIL sweep_n2_t%0d actual=%0d required=%0d", t, $signed(dout_n2), h2[t-N2_LAT]);
                end
            end
            if (t >= N9_LAT) begin
                checks++;
                if (dout_n9 !== N9_OW'(h9[t-N9_LAT])) begin
                    failures++;
                    $display("FAIL sweep_n9_t%0d actual=%0d required=%0d", t, $signed(dout_n9), h9[t-N9_LAT]);
                end
                checks++;
                if (dout_n16 !== N16_OW'(h16[t-N16_LAT])) begin
                    failures++;
                    $display("FAIL sweep_n16_t%0d actual=%0d required=%0d", t, $signed(dout_n16), h16[t-N16_LAT]);
                end
            end
            for (int j = 0; j < 2; j++) din_n2[j*8 +: 8] = 8'($urandom);
            for (int j = 0; j < 9; j++) din_n9[j*16 +: 16] = 16'($urandom);
            for (int j = 0; j < 16; j++) din_n16[j*8 +: 8] = 8'($urandom);
            // Force the extreme corner into the first few vectors.
            if (t == 1) begin
                din_n2  = {2{8'h80}};
                din_n9  = {9{16'h8000}};
                din_n16 = {16{8'h80}};
            end
            h2[t]  = sum_ops(288'(din_n2), 2, 8);
            h9[t]  = sum_ops(288'(din_n9), 9, 16);
            h16[t] = sum_ops(288'(din_n16), 16, 8);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        din      = '0;
        din_n2   = '0;
        din_n9   = '0;
        din_n16  = '0;
        test_reset();
        test_extremes();
        test_random_hold();
        test_back_to_back();
        test_mid_reset();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
